// File: rtl/data_mem_burst_pkg.sv
// data_mem_burst_pkg: reset polarity constants and FSM state encoding shared by the memory slice
package data_mem_burst_pkg;
   localparam logic ASSERT_L   = 1'b0;
   localparam logic DEASSERT_L = 1'b1;
   localparam logic ASSERT_H   = 1'b1;
   localparam logic DEASSERT_H = 1'b0;
   typedef enum logic [1:0] {
      IDLE  = 2'h0,
      WRITE = 2'h1,
      READ  = 2'h2,
      CLEAR = 2'h3
   } state_t;
endpackage

// File: rtl/data_mem_burst_if.sv
// data_mem_burst_if: command, write-beat and read-beat channels of the burst memory
interface data_mem_burst_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 10,
   parameter int BURST_WIDTH = 4
);
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic                    cmd_wr;
   logic [ADDR_WIDTH-1:0]   cmd_addr;
   logic [BURST_WIDTH-1:0]  cmd_burst;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [DATA_WIDTH/8-1:0] wr_be;
   logic                    wr_data_valid;
   logic                    wr_data_ready;
   logic [DATA_WIDTH-1:0]   rd_data;
   logic                    rd_data_valid;
   logic                    busy;
   modport master (
      output cmd_valid, cmd_wr, cmd_addr, cmd_burst, wr_data, wr_be, wr_data_valid,
      input  cmd_ready, wr_data_ready, rd_data, rd_data_valid, busy
   );
   modport slave (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_burst, wr_data, wr_be, wr_data_valid,
      output cmd_ready, wr_data_ready, rd_data, rd_data_valid, busy
   );
endinterface

// File: rtl/data_mem_rd_pipe.sv
// data_mem_rd_pipe: RD_LATENCY-deep {valid, data} shift register; data stages only load on valid beats
module data_mem_rd_pipe
   import data_mem_burst_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_data_valid,
   output logic                  busy
);
   logic [RD_LATENCY-1:0] vld;
   logic [DATA_WIDTH-1:0] dat [RD_LATENCY];
   // gating the data load on valid makes rd_data hold its last beat between bursts
   always_ff @(posedge clk or negedge reset)
      if (reset == ASSERT_L) begin
         vld <= '0;
         for (int i = 0; i < RD_LATENCY; i++) dat[i] <= '0;
      end else begin
         vld[0] <= in_valid;
         if (in_valid) dat[0] <= in_data;
         for (int i = 1; i < RD_LATENCY; i++) begin
            vld[i] <= vld[i-1];
            if (vld[i-1]) dat[i] <= dat[i-1];
         end
      end
   assign rd_data       = dat[RD_LATENCY-1];
   assign rd_data_valid = vld[RD_LATENCY-1];
   assign busy          = |vld;
endmodule

// File: rtl/data_mem_burst.sv
// data_mem_burst: single-port burst memory with byte-enable writes, pipelined reads and optional zero-fill
module data_mem_burst
   import data_mem_burst_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 10,
   parameter int MEM_DEPTH      = 1 << ADDR_WIDTH,
   parameter int BURST_WIDTH    = 4,
   parameter int RD_LATENCY     = 2,
   parameter bit CLEAR_ON_RESET = 1
) (
   input logic             clk,
   input logic             reset,
   data_mem_burst_if.slave bus
);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
   state_t                 state;
   logic [ADDR_WIDTH-1:0]  addr, addr_nxt, clr_ptr;
   logic [BURST_WIDTH-1:0] cnt;
   logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];
   logic                   cmd_rdy, wr_rdy, issue, wr_beat, last, pipe_busy;
   assign addr_nxt          = addr == LAST_ADDR ? '0 : addr + 1'b1;
   assign issue             = state == READ;
   assign wr_beat           = state == WRITE && bus.wr_data_valid;
   assign last              = cnt == BURST_WIDTH'(1);
   assign bus.cmd_ready     = cmd_rdy;
   assign bus.wr_data_ready = wr_rdy;
   assign bus.busy          = ~cmd_rdy | pipe_busy;
   always_ff @(posedge clk or negedge reset)
      if (reset == ASSERT_L) begin
         state   <= CLEAR_ON_RESET ? CLEAR : IDLE;
         clr_ptr <= '0;
         addr    <= '0;
         cnt     <= '0;
         cmd_rdy <= DEASSERT_H;
         wr_rdy  <= DEASSERT_H;
      end else
         case (state)
            CLEAR: begin
               clr_ptr <= clr_ptr + 1'b1;
               if (clr_ptr == LAST_ADDR) begin
                  state   <= IDLE;
                  cmd_rdy <= ASSERT_H;
               end
            end
            IDLE: begin
               cmd_rdy <= ASSERT_H;
               if (bus.cmd_valid && cmd_rdy) begin
                  addr <= bus.cmd_addr;
                  cnt  <= bus.cmd_burst;
                  // a zero-length burst is consumed without leaving IDLE
                  if (bus.cmd_burst != '0) begin
                     state   <= bus.cmd_wr ? WRITE : READ;
                     cmd_rdy <= DEASSERT_H;
                     wr_rdy  <= bus.cmd_wr;
                  end
               end
            end
            WRITE:
               if (bus.wr_data_valid) begin
                  addr <= addr_nxt;
                  cnt  <= cnt - 1'b1;
                  if (last) begin
                     state   <= IDLE;
                     cmd_rdy <= ASSERT_H;
                     wr_rdy  <= DEASSERT_H;
                  end
               end
            default: begin
               addr <= addr_nxt;
               cnt  <= cnt - 1'b1;
               if (last) begin
                  state   <= IDLE;
                  cmd_rdy <= ASSERT_H;
               end
            end
         endcase
   always_ff @(posedge clk)
      if (reset == DEASSERT_L && state == CLEAR) mem[clr_ptr] <= '0;
      else if (wr_beat)
         for (int b = 0; b < DATA_WIDTH / 8; b++)
            if (bus.wr_be[b]) mem[addr][8*b +: 8] <= bus.wr_data[8*b +: 8];
   data_mem_rd_pipe #(
      .DATA_WIDTH(DATA_WIDTH),
      .RD_LATENCY(RD_LATENCY)
   ) u_rd_pipe (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (issue),
      .in_data      (mem[addr]),
      .rd_data      (bus.rd_data),
      .rd_data_valid(bus.rd_data_valid),
      .busy         (pipe_busy)
   );
endmodule
